// File: rtl/rope_unit.sv
// ---------------------------------------------------------------------------
// rope_unit
//
// Harpoon-rope generator for the game screen. A rising edge on the fire key
// launches a rope at the player's column; its tip climbs from the floor
// toward the ceiling by a fixed step on every frame pulse. The rope retracts
// when it reaches the ceiling or when the collision logic reports a ball hit.
// Per pixel it produces a registered drawing request and a constant colour
// for the object priority multiplexer.
//
// Build option:
//   ROPE_STICKY_EN  - when defined, the rope holds at the ceiling for
//                     HOLD_FRAMES frames (or until hit) before retracting.
//                     When undefined, the rope retracts on the frame its tip
//                     reaches the ceiling.
//
// Ports:
//   clk                 in   pixel clock
//   resetN              in   asynchronous active-low reset
//   startOfFrame        in   one-cycle pulse per frame
//   fireKey             in   fire key level (already synchronous to clk)
//   ropeHit             in   rope/ball collision pulse
//   playerX     [10:0]  in   player left column
//   pixelX      [10:0]  in   current pixel column
//   pixelY      [10:0]  in   current pixel row
//   ropeDrawingRequest  out  current pixel is rope (one clk behind pixelX/Y)
//   ropeRGB     [7:0]   out  rope colour, RRRGGGBB, constant
//   ropeActive          out  rope is launched (any state other than idle)
//   ropeTipY    [10:0]  out  current tip row
// ---------------------------------------------------------------------------
module rope_unit #(
    parameter logic [10:0] FLOOR_Y     = 11'd440,
    parameter logic [10:0] CEILING_Y   = 11'd16,
    parameter logic [10:0] SPEED       = 11'd8,
    parameter logic [10:0] ROPE_WIDTH  = 11'd2,
    parameter logic [10:0] X_OFFSET    = 11'd15,
    parameter logic [5:0]  HOLD_FRAMES = 6'd30,
    parameter logic [7:0]  ROPE_COLOR  = 8'hDB
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        fireKey,
    input  logic        ropeHit,
    input  logic [10:0] playerX,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        ropeDrawingRequest,
    output logic [7:0]  ropeRGB,
    output logic        ropeActive,
    output logic [10:0] ropeTipY
);

`ifdef ROPE_STICKY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXTEND = 2'd1,
        S_HOLD   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXTEND = 2'd1
    } state_t;
`endif

    // A tip at or below this row reaches the ceiling on the next step.
    localparam logic [10:0] CEIL_THRESH = CEILING_Y + SPEED;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q;
    logic        fire_key_q;     // previous fireKey, for edge detection
    logic [10:0] rope_x_q;       // left column of the rope
    logic [10:0] tip_q;          // current tip row
    logic        draw_q;         // registered drawing request
`ifdef ROPE_STICKY_EN
    logic [5:0]  hold_cnt_q;     // frames left at the ceiling
`else
    // The hold time only matters for the sticky build.
    logic        unused_hold_cfg;
    assign unused_hold_cfg = ^HOLD_FRAMES;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        fire_rise;
    logic        reach_ceiling;
    logic [10:0] rope_x_d;
    logic [10:0] tip_step_d;
    logic [10:0] rope_x_end;
    logic        in_col;
    logic        in_row;
    logic        draw_d;

    // fire_key_q resets high so a key held through reset does not fire.
    assign fire_rise     = fireKey & ~fire_key_q;
    assign reach_ceiling = (tip_q <= CEIL_THRESH);
    // Column wraps in 11 bits; the playfield logic keeps the player in range.
    assign rope_x_d      = playerX + X_OFFSET;
    assign tip_step_d    = tip_q - SPEED;

    assign rope_x_end = rope_x_q + ROPE_WIDTH;
    assign in_col     = (pixelX >= rope_x_q) && (pixelX < rope_x_end);
    assign in_row     = (pixelY >= tip_q) && (pixelY < FLOOR_Y);
    assign draw_d     = (state_q != S_IDLE) && in_col && in_row;

    // ------------------------------------------------------------------
    // Rope FSM with its registered datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            fire_key_q <= 1'b1;
            rope_x_q   <= 11'd0;
            tip_q      <= FLOOR_Y;
            draw_q     <= 1'b0;
`ifdef ROPE_STICKY_EN
            hold_cnt_q <= 6'd0;
`endif
        end else begin
            fire_key_q <= fireKey;
            draw_q     <= draw_d;

            case (state_q)
                S_IDLE: begin
                    // Launch happens immediately; the first rise waits for
                    // the next frame pulse even if one is present now.
                    if (fire_rise) begin
                        state_q  <= S_EXTEND;
                        rope_x_q <= rope_x_d;
                    end
                    // While idle the tip is parked at the floor. This also
                    // returns a tip left at the ceiling (non-sticky retract)
                    // to the floor one clock after retracting.
                    tip_q <= FLOOR_Y;
                end

                S_EXTEND: begin
                    // A hit takes priority over a coincident frame pulse.
                    if (ropeHit) begin
                        state_q <= S_IDLE;
                        tip_q   <= FLOOR_Y;
                    end else if (startOfFrame) begin
                        if (reach_ceiling) begin
                            tip_q <= CEILING_Y;
`ifdef ROPE_STICKY_EN
                            state_q    <= S_HOLD;
                            hold_cnt_q <= HOLD_FRAMES;
`else
                            state_q <= S_IDLE;
`endif
                        end else begin
                            tip_q <= tip_step_d;
                        end
                    end
                end

`ifdef ROPE_STICKY_EN
                S_HOLD: begin
                    if (ropeHit) begin
                        state_q    <= S_IDLE;
                        tip_q      <= FLOOR_Y;
                        hold_cnt_q <= 6'd0;
                    end else if (startOfFrame) begin
                        // Count reaching zero on this pulse ends the hold;
                        // a zero load also releases on the first pulse.
                        if (hold_cnt_q <= 6'd1) begin
                            state_q    <= S_IDLE;
                            tip_q      <= FLOOR_Y;
                            hold_cnt_q <= 6'd0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q - 6'd1;
                        end
                    end
                end
`endif

                default: begin
                    state_q <= S_IDLE;
                    tip_q   <= FLOOR_Y;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ropeDrawingRequest = draw_q;
    assign ropeRGB            = ROPE_COLOR;
    assign ropeActive         = (state_q != S_IDLE);
    assign ropeTipY           = tip_q;

endmodule

// File: tb/tb_rope_unit.sv
// ---------------------------------------------------------------------------
// tb_rope_unit
//
// Self-checking bench for rope_unit. Directed scenarios plus a randomized
// phase are compared cycle by cycle against a behavioural rope model.
// Build with ROPE_STICKY_EN defined to exercise the ceiling-hold variant.
// ---------------------------------------------------------------------------
module tb_rope_unit;

    localparam int FLOOR = 440;
    localparam int CEIL  = 16;
    localparam int SPD   = 8;
    localparam int WID   = 2;
    localparam int XOFF  = 15;
    localparam int HOLDF = 30;
    localparam int RGB   = 8'hDB;
`ifdef ROPE_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        fireKey;
    logic        ropeHit;
    logic [10:0] playerX;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        ropeDrawingRequest;
    logic [7:0]  ropeRGB;
    logic        ropeActive;
    logic [10:0] ropeTipY;

    rope_unit dut (
        .clk                (clk),
        .resetN             (resetN),
        .startOfFrame       (startOfFrame),
        .fireKey            (fireKey),
        .ropeHit            (ropeHit),
        .playerX            (playerX),
        .pixelX             (pixelX),
        .pixelY             (pixelY),
        .ropeDrawingRequest (ropeDrawingRequest),
        .ropeRGB            (ropeRGB),
        .ropeActive         (ropeActive),
        .ropeTipY           (ropeTipY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a rope is either absent, climbing, or holding.
    // ------------------------------------------------------------------
    bit m_active;
    bit m_hold;
    int m_hold_left;
    int m_tip;
    int m_x;
    bit m_prev;
    int m_req;

    task automatic model_reset();
        m_active    = 1'b0;
        m_hold      = 1'b0;
        m_hold_left = 0;
        m_tip       = FLOOR;
        m_x         = 0;
        m_prev      = 1'b1;
        m_req       = 0;
    endtask

    // Advance model and DUT by one clock, then compare.
    task automatic tick();
        int px;
        int py;
        int nreq;
        bit rise;
        px   = int'(pixelX);
        py   = int'(pixelY);
        nreq = (m_active && px >= m_x && px < m_x + WID &&
                py >= m_tip && py < FLOOR) ? 1 : 0;
        rise   = fireKey && !m_prev;
        m_prev = fireKey;
        if (!m_active) begin
            m_tip = FLOOR;
            if (rise) begin
                m_active = 1'b1;
                m_hold   = 1'b0;
                m_x      = (int'(playerX) + XOFF) % 2048;
            end
        end else if (ropeHit) begin
            m_active = 1'b0;
            m_hold   = 1'b0;
            m_tip    = FLOOR;
        end else if (m_hold) begin
            if (startOfFrame) begin
                m_hold_left--;
                if (m_hold_left <= 0) begin
                    m_active = 1'b0;
                    m_hold   = 1'b0;
                    m_tip    = FLOOR;
                end
            end
        end else if (startOfFrame) begin
            if (m_tip <= CEIL + SPD) begin
                m_tip = CEIL;
                if (STICKY) begin
                    m_hold      = 1'b1;
                    m_hold_left = HOLDF;
                end else begin
                    m_active = 1'b0;
                end
            end else begin
                m_tip = m_tip - SPD;
            end
        end
        m_req = nreq;
        @(posedge clk);
        #1;
        check("cyc_req", int'(ropeDrawingRequest), m_req);
        check("cyc_active", int'(ropeActive), int'(m_active));
        check("cyc_tip", int'(ropeTipY), m_tip);
    endtask

    task automatic sof_tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fire_at(input int px);
        fireKey = 1'b0;
        tick();
        playerX = 11'(px);
        fireKey = 1'b1;
        tick();
        fireKey = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic mid_reset();
        #2;
        resetN = 1'b0;
        #1;
        check("async_rst_active", int'(ropeActive), 0);
        check("async_rst_tip", int'(ropeTipY), FLOOR);
        check("async_rst_req", int'(ropeDrawingRequest), 0);
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        $display("async reset applied mid-cycle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN       = 1'b0;
        fireKey      = 1'b1;
        startOfFrame = 1'b0;
        ropeHit      = 1'b0;
        playerX      = 11'd0;
        pixelX       = 11'd0;
        pixelY       = 11'd0;
        model_reset();

        // Reset with fire held.
        repeat (3) @(posedge clk);
        #1;
        check("rst_active", int'(ropeActive), 0);
        check("rst_tip", int'(ropeTipY), FLOOR);
        check("rst_req", int'(ropeDrawingRequest), 0);
        check("rgb", int'(ropeRGB), RGB);
        resetN = 1'b1;
        gap(3);
        check("held_key_no_fire", int'(ropeActive), 0);
        check("held_key_tip", int'(ropeTipY), 440);
        $display("reset released with fire held: active=%0d", ropeActive);

        // Fire latency and the climb.
        fire_at(100);
        check("fire_latency", int'(ropeActive), 1);
        $display("fire at playerX=100: active=%0d tip=%0d", ropeActive, ropeTipY);
        for (int k = 1; k <= 53; k++) begin
            sof_tick();
            if (k == 1)  check("tip_pulse1", int'(ropeTipY), 432);
            if (k == 52) check("tip_pulse52", int'(ropeTipY), 24);
            if (k == 53) begin
                check("tip_pulse53", int'(ropeTipY), 16);
                check("active_pulse53", int'(ropeActive), STICKY ? 1 : 0);
            end
            gap(2);
        end
        $display("climb done: active=%0d", ropeActive);

`ifdef ROPE_STICKY_EN
        for (int k = 1; k <= 30; k++) begin
            sof_tick();
            if (k == 29) check("hold_29", int'(ropeActive), 1);
            if (k == 30) check("hold_30", int'(ropeActive), 0);
            gap(1);
        end
        $display("hold expired: active=%0d", ropeActive);
`endif
        gap(3);

        // Raster scan around a rope at tip 200, column 115.
        fire_at(100);
        for (int k = 0; k < 30; k++) begin
            sof_tick();
            gap(1);
        end
        check("tip_200", int'(ropeTipY), 200);
        begin
            int ys [5] = '{199, 200, 300, 439, 440};
            for (int yi = 0; yi < 5; yi++) begin
                for (int x = 113; x <= 118; x++) begin
                    pixelX = 11'(x);
                    pixelY = 11'(ys[yi]);
                    tick();
                    check("scan_req", int'(ropeDrawingRequest),
                          (x >= 115 && x <= 116 && ys[yi] >= 200 && ys[yi] <= 439) ? 1 : 0);
                end
                $display("scan row %0d done", ys[yi]);
            end
        end

        // Clear, relaunch, hit coinciding with a frame pulse at tip 304.
        ropeHit = 1'b1;
        tick();
        ropeHit = 1'b0;
        check("hit_clear", int'(ropeActive), 0);
        fire_at(100);
        for (int k = 0; k < 17; k++) begin
            sof_tick();
            gap(1);
        end
        check("tip_304", int'(ropeTipY), 304);
        pixelX       = 11'd115;
        pixelY       = 11'd350;
        ropeHit      = 1'b1;
        startOfFrame = 1'b1;
        tick();
        ropeHit      = 1'b0;
        startOfFrame = 1'b0;
        check("hit_sof_active", int'(ropeActive), 0);
        check("hit_sof_tip", int'(ropeTipY), 440);
        tick();
        check("hit_sof_req", int'(ropeDrawingRequest), 0);
        $display("hit with frame pulse: active=%0d tip=%0d", ropeActive, ropeTipY);

        // Hit while idle is ignored.
        ropeHit = 1'b1;
        tick();
        ropeHit = 1'b0;
        check("idle_hit", int'(ropeActive), 0);

        // Second press during flight is dropped.
        fire_at(100);
        for (int k = 0; k < 3; k++) begin
            sof_tick();
            gap(1);
        end
        fire_at(300);
        check("refire_active", int'(ropeActive), 1);
        sof_tick();
        check("refire_tip", int'(ropeTipY), 408);
        pixelX = 11'd115;
        pixelY = 11'd420;
        gap(2);
        check("refire_old_col", int'(ropeDrawingRequest), 1);
        pixelX = 11'd315;
        gap(2);
        check("refire_new_col", int'(ropeDrawingRequest), 0);
        $display("second press ignored: tip=%0d", ropeTipY);
        ropeHit = 1'b1;
        tick();
        ropeHit = 1'b0;

        // Randomized phase.
        for (int c = 0; c < 4000; c++) begin
            startOfFrame = ($urandom_range(0, 15) == 0);
            ropeHit      = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) fireKey = ~fireKey;
            if ($urandom_range(0, 31) == 0) playerX = 11'($urandom_range(0, 1000));
            if ($urandom_range(0, 1) == 0)
                pixelX = 11'(m_x + $urandom_range(0, 5) - 2);
            else
                pixelX = 11'($urandom_range(0, 1100));
            pixelY = 11'($urandom_range(0, 520));
            tick();
            if (c == 2000) mid_reset();
            if (startOfFrame)
                $display("frame c=%0d active=%0d tip=%0d", c, ropeActive, ropeTipY);
        end
        startOfFrame = 1'b0;
        ropeHit      = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
